// File: rtl/risc_mgmt_decode_arbiter_if.sv
// Decode-claim bus between the decode stage, the RISC-MGMT extensions and the arbiter.
// The master side drives instruction/claim information; the slave side returns the grant.
interface risc_mgmt_decode_arbiter_if #(
    parameter int N_EXT = 4
);
    logic               insn_valid;
    logic               stall;
    logic [N_EXT-1:0]   ext_claim;
    logic [N_EXT-1:0]   ext_bubble;
    logic [5*N_EXT-1:0] ext_rsel_s_0;
    logic [5*N_EXT-1:0] ext_rsel_s_1;
    logic [5*N_EXT-1:0] ext_rsel_d;
    logic [N_EXT-1:0]   grant;
    logic               claimed;
    logic [4:0]         rsel_s_0;
    logic [4:0]         rsel_s_1;
    logic [4:0]         rsel_d;
    logic               bubble;
    logic               conflict;
    logic               timeout_err;
    logic [7:0]         conflict_cnt;

    modport master (
        output insn_valid, stall, ext_claim, ext_bubble, ext_rsel_s_0, ext_rsel_s_1, ext_rsel_d,
        input  grant, claimed, rsel_s_0, rsel_s_1, rsel_d, bubble, conflict, timeout_err, conflict_cnt
    );

    modport slave (
        input  insn_valid, stall, ext_claim, ext_bubble, ext_rsel_s_0, ext_rsel_s_1, ext_rsel_d,
        output grant, claimed, rsel_s_0, rsel_s_1, rsel_d, bubble, conflict, timeout_err, conflict_cnt
    );
endinterface

// File: rtl/risc_mgmt_decode_arbiter.sv
// Round-robin owner selection for the shared decode claim path, with a bubble-hold
// lock on the granted extension and a bounded hold time.
module risc_mgmt_decode_arbiter #(
    parameter int N_EXT          = 4,
    parameter int BUBBLE_TIMEOUT = 15
) (
    input  logic                      CLK,
    input  logic                      nRST,
    risc_mgmt_decode_arbiter_if.slave bus
);
    localparam int PW = (N_EXT > 1) ? $clog2(N_EXT) : 1;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     lock_q, lock_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic [7:0]        conflict_cnt_q, conflict_cnt_d;

    logic [PW-1:0]     sel;
    logic [PW-1:0]     cand;
    logic              found;
    logic              claimed_c;
    logic              bubble_c;
    logic              conflict_c;
    logic              timeout_c;
    logic [N_EXT-1:0]  grant_c;

    logic [4:0]        rs0_arr [N_EXT];
    logic [4:0]        rs1_arr [N_EXT];
    logic [4:0]        rd_arr  [N_EXT];

    genvar gi;
    generate
        for (gi = 0; gi < N_EXT; gi++) begin : g_unpack
            assign rs0_arr[gi] = bus.ext_rsel_s_0[5*gi +: 5];
            assign rs1_arr[gi] = bus.ext_rsel_s_1[5*gi +: 5];
            assign rd_arr[gi]  = bus.ext_rsel_d[5*gi +: 5];
        end
    endgenerate

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == N_EXT - 1) ? '0 : PW'(int'(p) + 1);
    endfunction

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        lock_d         = lock_q;
        hold_cnt_d     = hold_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        sel            = '0;
        cand           = '0;
        found          = 1'b0;
        claimed_c      = 1'b0;
        bubble_c       = 1'b0;
        conflict_c     = 1'b0;
        timeout_c      = 1'b0;
        grant_c        = '0;

        case (state_q)
            IDLE: begin
                if (bus.insn_valid) begin
                    conflict_c = ($countones(bus.ext_claim) >= 2);
                    // First claimer at or after rr_ptr, wrapping around.
                    for (int k = 0; k < N_EXT; k++) begin
                        cand = PW'((int'(rr_ptr_q) + k) % N_EXT);
                        if (!found && bus.ext_claim[cand]) begin
                            found = 1'b1;
                            sel   = cand;
                        end
                    end
                end
                if (found) begin
                    claimed_c = 1'b1;
                    bubble_c  = bus.ext_bubble[sel];
                    if (!bus.stall) begin
                        rr_ptr_d = ptr_inc(sel);
                    end
                    // A bubble request locks the slot even while stalled.
                    if (bus.ext_bubble[sel]) begin
                        state_d    = HOLD;
                        lock_d     = sel;
                        hold_cnt_d = '0;
                    end
                end
                if (conflict_c && !bus.stall && conflict_cnt_q != 8'hFF) begin
                    conflict_cnt_d = conflict_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                found     = 1'b1;
                sel       = lock_q;
                claimed_c = 1'b1;
                if (!bus.ext_bubble[lock_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_inc(lock_q);
                end else if (hold_cnt_q == 8'(BUBBLE_TIMEOUT)) begin
                    timeout_c = 1'b1;
                    state_d   = IDLE;
                    rr_ptr_d  = ptr_inc(lock_q);
                end else begin
                    bubble_c   = 1'b1;
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (found) begin
            grant_c[sel] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            lock_q         <= '0;
            hold_cnt_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            lock_q         <= lock_d;
            hold_cnt_q     <= hold_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Outputs are forced quiet for the whole reset window, not just after the first edge.
    assign bus.grant        = nRST ? grant_c : '0;
    assign bus.claimed      = nRST & claimed_c;
    assign bus.bubble       = nRST & bubble_c;
    assign bus.conflict     = nRST & conflict_c;
    assign bus.timeout_err  = nRST & timeout_c;
    assign bus.rsel_s_0     = (nRST && found) ? rs0_arr[sel] : 5'd0;
    assign bus.rsel_s_1     = (nRST && found) ? rs1_arr[sel] : 5'd0;
    assign bus.rsel_d       = (nRST && found) ? rd_arr[sel]  : 5'd0;
    assign bus.conflict_cnt = conflict_cnt_q;
endmodule
